// File: rtl/data_memory_dump_ctrl_if.sv
// Memory debug-read port and UART TX handshake between the dump sequencer
// (master) and the memory / transmitter side (slave).
interface data_memory_dump_ctrl_if #(
  parameter int MEMORY_WIDTH = 8,
  parameter int NB_ADDR      = 7
);
  logic [MEMORY_WIDTH-1:0] i_mem_byte;
  logic                    i_tx_ready;
  logic                    o_mem_read_enable;
  logic [NB_ADDR-1:0]      o_mem_read_address;
  logic [MEMORY_WIDTH-1:0] o_tx_data;
  logic                    o_tx_valid;

  modport master (
    input  i_mem_byte, i_tx_ready,
    output o_mem_read_enable, o_mem_read_address, o_tx_data, o_tx_valid
  );

  modport slave (
    output i_mem_byte, i_tx_ready,
    input  o_mem_read_enable, o_mem_read_address, o_tx_data, o_tx_valid
  );
endinterface

// File: rtl/data_memory_dump_ctrl.sv
// Walks the data memory debug read port from 0 to MEMORY_DEPTH-1 and streams each byte to UART TX.
// Optional macro DUMP_CHECKSUM_EN appends a two's-complement checksum byte before o_done.
module data_memory_dump_ctrl #(
  parameter int MEMORY_WIDTH = 8,
  parameter int MEMORY_DEPTH = 128,
  parameter int NB_ADDR      = 7
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_start,
  data_memory_dump_ctrl_if.master  dump,
  output logic                     o_busy,
  output logic                     o_done
);

`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_READ, S_LATCH, S_SEND, S_CHK, S_DONE} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_READ, S_LATCH, S_SEND, S_DONE} state_e;
`endif

  state_e                  state_q, state_d;
  logic [NB_ADDR-1:0]      cnt_q, cnt_d;
  logic [NB_ADDR-1:0]      rd_addr_q, rd_addr_d;
  logic [MEMORY_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                    last_byte;
  logic                    xfer;

  assign last_byte = (cnt_q == NB_ADDR'(MEMORY_DEPTH - 1));
  assign xfer      = (state_q == S_SEND) && dump.i_tx_ready;

`ifdef DUMP_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;

  function automatic logic [7:0] negate8(input logic [7:0] s);
    return 8'd0 - s;
  endfunction
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_READ;
      S_READ:  state_d = S_LATCH;
      S_LATCH: state_d = S_SEND;
`ifdef DUMP_CHECKSUM_EN
      S_SEND:  if (xfer) state_d = last_byte ? S_CHK : S_READ;
      S_CHK:   if (dump.i_tx_ready) state_d = S_DONE;
`else
      S_SEND:  if (xfer) state_d = last_byte ? S_DONE : S_READ;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter, held address, outgoing byte (and running sum) advance with the FSM
  always_comb begin
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    tx_data_d = tx_data_q;
`ifdef DUMP_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      S_IDLE: if (i_start) begin
        cnt_d = '0;
`ifdef DUMP_CHECKSUM_EN
        sum_d = '0;
`endif
      end
      S_READ:  rd_addr_d = cnt_q;
      S_LATCH: tx_data_d = dump.i_mem_byte;
      S_SEND: if (xfer) begin
`ifdef DUMP_CHECKSUM_EN
        sum_d = sum_q + tx_data_q[7:0];
        if (last_byte) tx_data_d = MEMORY_WIDTH'(negate8(sum_d));
`endif
        if (!last_byte) cnt_d = cnt_q + NB_ADDR'(1);
      end
      S_DONE:  cnt_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt_q     <= '0;
      rd_addr_q <= '0;
      tx_data_q <= '0;
`ifdef DUMP_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      tx_data_q <= tx_data_d;
`ifdef DUMP_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  // Outside READ the address port keeps showing the last address that was read
  always_comb begin
    o_busy                  = (state_q != S_IDLE);
    o_done                  = (state_q == S_DONE);
    dump.o_mem_read_enable  = (state_q == S_READ);
    dump.o_mem_read_address = (state_q == S_READ) ? cnt_q : rd_addr_q;
    dump.o_tx_data          = tx_data_q;
`ifdef DUMP_CHECKSUM_EN
    dump.o_tx_valid         = (state_q == S_SEND) || (state_q == S_CHK);
`else
    dump.o_tx_valid         = (state_q == S_SEND);
`endif
  end

endmodule

// File: tb/tb_data_memory_dump_ctrl.sv
// Self-checking bench for data_memory_dump_ctrl: step table, directed corner sequences
// and randomized memory images / backpressure against a byte-list reference model.
module tb_data_memory_dump_ctrl;
  localparam int W = 8;
  localparam int D = 128;
  localparam int A = 7;
`ifdef DUMP_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif
  localparam int FULL_CYC = 3 * D + 1 + CHK;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done;

  data_memory_dump_ctrl_if #(.MEMORY_WIDTH(W), .NB_ADDR(A)) dif();

  data_memory_dump_ctrl #(.MEMORY_WIDTH(W), .MEMORY_DEPTH(D), .NB_ADDR(A)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .i_start (start),
    .dump    (dif),
    .o_busy  (busy),
    .o_done  (done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [D];
  always @(posedge clk)
    if (dif.o_mem_read_enable) dif.i_mem_byte <= mem[dif.o_mem_read_address];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] got_q [$];
  int done_cnt, overlap_cnt, stab_cnt;
  logic prev_hold;
  logic [7:0] prev_data;

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (dif.o_tx_valid && dif.i_tx_ready) got_q.push_back(dif.o_tx_data);
      if (dif.o_tx_valid && dif.o_mem_read_enable) overlap_cnt++;
      if (prev_hold && (!dif.o_tx_valid || dif.o_tx_data !== prev_data)) stab_cnt++;
      prev_hold = dif.o_tx_valid && !dif.i_tx_ready;
      prev_data = dif.o_tx_data;
      if (done) done_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] outs();
    return {busy, dif.o_mem_read_enable, dif.o_mem_read_address, dif.o_tx_valid, dif.o_tx_data, done};
  endfunction

  // Reference: the dump is simply the memory image in address order, plus the
  // byte that brings the modulo-256 total to zero when the checksum is enabled.
  task automatic compare_seq(input string name);
    logic [7:0] exp_q [$];
    int s = 0;
    for (int i = 0; i < D; i++) begin
      exp_q.push_back(mem[i]);
      s += int'(mem[i]);
    end
    if (CHK == 1) exp_q.push_back(8'((256 - (s % 256)) % 256));
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", name, i), got_q[i], exp_q[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    done_cnt = 0;
    overlap_cnt = 0;
    stab_cnt = 0;
  endtask

  // Returns at #1 after the edge that puts the DUT into its o_done cycle.
  task automatic run_dump(input int rmode, input int stall_byte, input int stall_len,
                          input int start_byte, output int cycles);
    int stall_left = stall_len;
    bit restarted = 0;
    clear_mon();
    dif.i_tx_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 1;
    while (!done && cycles < 4000) begin
      if (rmode == 1) dif.i_tx_ready = 1'($urandom_range(0, 1));
      else dif.i_tx_ready = 1'b1;
      if (dif.o_tx_valid && got_q.size() == stall_byte && stall_left > 0) begin
        dif.i_tx_ready = 1'b0;
        stall_left--;
      end
      if (!restarted && got_q.size() == start_byte) begin
        start = 1'b1;
        restarted = 1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    dif.i_tx_ready = 1'b1;
    check("done_reached", done, 1'b1);
  endtask

  typedef struct {
    logic       st;
    logic       rdy;
    logic [18:0] exp;
  } vec_t;
  vec_t tbl [8];

  initial begin
    int cyc;
    int guard;

    dif.i_tx_ready = 1'b0;
    dif.i_mem_byte = '0;
    prev_hold = 1'b0;
    clear_mon();
    for (int i = 0; i < D; i++) mem[i] = 8'(i);
    mem[0] = 8'h5A;
    mem[1] = 8'hFF;

    // {busy, re, addr[6:0], valid, data[7:0], done}
    tbl[0] = '{1'b0, 1'b1, {1'b0, 1'b0, 7'd0, 1'b0, 8'h00, 1'b0}};
    tbl[1] = '{1'b1, 1'b1, {1'b1, 1'b1, 7'd0, 1'b0, 8'h00, 1'b0}};
    tbl[2] = '{1'b0, 1'b1, {1'b1, 1'b0, 7'd0, 1'b0, 8'h00, 1'b0}};
    tbl[3] = '{1'b0, 1'b0, {1'b1, 1'b0, 7'd0, 1'b1, 8'h5A, 1'b0}};
    tbl[4] = '{1'b0, 1'b0, {1'b1, 1'b0, 7'd0, 1'b1, 8'h5A, 1'b0}};
    tbl[5] = '{1'b1, 1'b1, {1'b1, 1'b1, 7'd1, 1'b0, 8'h5A, 1'b0}};
    tbl[6] = '{1'b0, 1'b1, {1'b1, 1'b0, 7'd1, 1'b0, 8'h5A, 1'b0}};
    tbl[7] = '{1'b0, 1'b0, {1'b1, 1'b0, 7'd1, 1'b1, 8'hFF, 1'b0}};

    repeat (3) @(posedge clk);
    #1 check("reset_outputs", outs(), 19'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", outs(), 19'd0);

    for (int i = 0; i < 8; i++) begin
      start = tbl[i].st;
      dif.i_tx_ready = tbl[i].rdy;
      @(posedge clk); #1;
      check($sformatf("step%0d", i), outs(), tbl[i].exp);
    end
    do_reset();

    // Full dump of the reference image, then start on the o_done cycle vs. the cycle after.
    run_dump(0, -1, 0, -1, cyc);
    check("full_cycles", cyc, FULL_CYC);
    compare_seq("full");
`ifdef DUMP_CHECKSUM_EN
    check("full_checksum", got_q[D], 8'hE8);
`endif
    check("full_overlap", overlap_cnt, 0);
    start = 1'b1;
    @(posedge clk); #1;
    check("start_on_done_ignored", busy, 1'b0);
    check("full_done_once", done_cnt, 1);
    @(posedge clk); #1;
    start = 1'b0;
    check("start_after_done", {busy, dif.o_mem_read_enable, dif.o_mem_read_address}, {2'b11, 7'd0});
    do_reset();

    run_dump(0, 5, 10, -1, cyc);
    check("stall_cycles", cyc, FULL_CYC + 10);
    compare_seq("stall");
    check("stall_byte5", got_q[5], 8'h05);
    check("stall_hold_stable", stab_cnt, 0);
    check("stall_no_read", overlap_cnt, 0);
    @(posedge clk); #1;
    check("stall_idle", busy, 1'b0);
    check("stall_done_once", done_cnt, 1);

    run_dump(0, -1, 0, 40, cyc);
    check("busy_start_cycles", cyc, FULL_CYC);
    compare_seq("busy_start");
    @(posedge clk); #1;
    check("busy_start_done_once", done_cnt, 1);
    check("busy_start_idle", busy, 1'b0);

    // Reset mid-dump at byte 60: outputs clear without waiting for a clock edge.
    clear_mon();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (got_q.size() < 60 && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("midreset_reach60", got_q.size() >= 60, 1'b1);
    #2 rst = 1'b1;
    #1 check("midreset_async_outputs", outs(), 19'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("midreset_no_done", done_cnt, 0);
    check("midreset_idle", busy, 1'b0);
    run_dump(0, -1, 0, -1, cyc);
    compare_seq("after_reset");
    @(posedge clk); #1;

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < D; i++) mem[i] = 8'($urandom);
      run_dump(1, $urandom_range(0, D - 1), $urandom_range(0, 6), $urandom_range(0, D - 1), cyc);
      compare_seq($sformatf("rand%0d", r));
      check($sformatf("rand%0d_hold", r), stab_cnt, 0);
      check($sformatf("rand%0d_overlap", r), overlap_cnt, 0);
      @(posedge clk); #1;
      check($sformatf("rand%0d_done_once", r), done_cnt, 1);
      check($sformatf("rand%0d_idle", r), busy, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
